instr_mem_loader: RTL and testbench

- Writer side of the instruction-memory interface. The fetch datapath only reads 32-bit instructions; this block fills that memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the 32-bit instruction memory at consecutive word addresses.
- Holds the processor in reset until the load completes.
- Sits beside the processor top. It drives the memory write port (wadress, Datain, Wr) and gates the processor's reset.

---
 rtl/instr_mem_loader_if.sv | 35 +++
 rtl/instr_mem_loader.sv | 205 ++++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if
//
// Groups the two buses the instruction-memory loader sits between.
//   Byte stream (valid/ready):
//     byte_in     8   stream data byte
//     byte_valid  1   byte_in is valid
//     byte_ready  1   loader accepts a byte this cycle
//   Instruction-memory write port:
//     mem_wadress 64  write word address (byte address, word aligned)
//     mem_datain  32  write data
//     mem_wr      1   write enable
//
// Modports:
//   master - the loader: consumes the stream, drives the memory write port.
//   slave  - the environment: sources the stream, observes the write port.
`timescale 1ns/1ps

interface instr_mem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [63:0] mem_wadress;
    logic [31:0] mem_datain;
    logic        mem_wr;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_wadress, mem_datain, mem_wr
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_wadress, mem_datain, mem_wr
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//
// Writer side of the 32-bit instruction memory. Collects a byte stream,
// assembles little-endian 32-bit words and writes them at consecutive word
// addresses starting at BASE_ADDR, holding the processor in reset until the
// whole image has been loaded.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      asynchronous active-low reset
//   start      in   1      single-cycle request to begin a load
//   len_words  in   LEN_W  words to load, sampled when start is accepted
//   bus        master      byte stream in, memory write port out
//   cpu_hold   out  1      processor held in reset while high
//   busy       out  1      load in progress
//   done       out  1      load completed, held until the next start
//   err        out  1      rejected request / checksum failure, sticky
//
// Build option:
//   LOADER_CHECKSUM_EN - after the last word one extra byte is accepted and
//   compared with the sum of all payload bytes mod 256; a mismatch sets err
//   and returns to IDLE with the processor still held.
`timescale 1ns/1ps

module instr_mem_loader #(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int          MAX_WORDS = 256,
    parameter int          LEN_W     = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len_words,
    instr_mem_loader_if.master      bus,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

    // One extra bit so a length of exactly 2^LEN_W-1 still compares correctly.
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_WORDS);

    state_t           state_q, state_d;
    logic [63:0]      addr_q, addr_d;
    logic [31:0]      datain_q, datain_d;
    logic [23:0]      wordBuf_q, wordBuf_d;
    logic [1:0]       byteIdx_q, byteIdx_d;
    logic [LEN_W-1:0] wordCnt_q, wordCnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
`endif

    logic byteReady;
    logic xfer;
    logic lenTooBig;

    // The stream is only drained while collecting payload (or the check
    // byte); outside those states a held-high byte_valid is simply ignored.
    always_comb begin
`ifdef LOADER_CHECKSUM_EN
        byteReady = (state_q == COLLECT) || (state_q == CHECK);
        busy      = (state_q == COLLECT) || (state_q == WRITE) || (state_q == CHECK);
`else
        byteReady = (state_q == COLLECT);
        busy      = (state_q == COLLECT) || (state_q == WRITE);
`endif
        xfer      = bus.byte_valid && byteReady;
        lenTooBig = {1'b0, len_words} > MAX_LEN;
    end

    // Output decode: the write strobe exists only in WRITE, while address and
    // data come straight from registers so they stay put between writes.
    always_comb begin
        bus.byte_ready  = byteReady;
        bus.mem_wr      = (state_q == WRITE);
        bus.mem_wadress = addr_q;
        bus.mem_datain  = datain_q;
        done            = (state_q == DONE);
        cpu_hold        = (state_q != DONE);
        err             = err_q;
    end

    // Next-state logic. The partial word lives in wordBuf until the fourth
    // byte arrives; only then is the full word moved into the output data
    // register, so mem_datain never shows a half-built word.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        datain_d  = datain_q;
        wordBuf_d = wordBuf_q;
        byteIdx_d = byteIdx_q;
        wordCnt_d = wordCnt_q;
        len_d     = len_q;
        err_d     = err_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (len_words == '0) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (lenTooBig) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        len_d     = len_words;
                        err_d     = 1'b0;
                        addr_d    = BASE_ADDR;
                        wordCnt_d = '0;
                        byteIdx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        sum_d     = 8'd0;
`endif
                        state_d   = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    byteIdx_d = byteIdx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d     = sum_q + bus.byte_in;
`endif
                    case (byteIdx_q)
                        2'd0: wordBuf_d[7:0]   = bus.byte_in;
                        2'd1: wordBuf_d[15:8]  = bus.byte_in;
                        2'd2: wordBuf_d[23:16] = bus.byte_in;
                        default: begin
                            datain_d = {bus.byte_in, wordBuf_q};
                            state_d  = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                addr_d    = addr_q + 64'd4;
                wordCnt_d = wordCnt_q + LEN_W'(1);
                if (wordCnt_q + LEN_W'(1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    if (bus.byte_in == sum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset drops any partial word and parks the address at
    // BASE_ADDR; memory contents already written are left alone.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            addr_q    <= BASE_ADDR;
            datain_q  <= 32'd0;
            wordBuf_q <= 24'd0;
            byteIdx_q <= 2'd0;
            wordCnt_q <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            datain_q  <= datain_d;
            wordBuf_q <= wordBuf_d;
            byteIdx_q <= byteIdx_d;
            wordCnt_q <= wordCnt_d;
            len_q     <= len_d;
            err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
//
// Drives byte images into instr_mem_loader and compares every memory write
// and status output with a reference model that derives the expected image
// directly from the byte list (word i = bytes 4i..4i+3, little-endian, at
// BASE + 4*i). Honours LOADER_CHECKSUM_EN by appending the payload sum.
`timescale 1ns/1ps

module tb_instr_mem_loader;

    localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
    localparam int          MAXW = 256;
    localparam int          LW   = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len_words = '0;
    logic          cpu_hold, busy, done, err;

    instr_mem_loader_if bus();

    instr_mem_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .LEN_W(LW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .len_words(len_words),
        .bus(bus),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .err(err)
    );

    // Free-running clock, 10 ns period.
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [63:0] wrAddr[$];
    logic [31:0] wrData[$];

    // Write monitor: every WRITE lasts one cycle, so sampling on the falling
    // edge records each write exactly once.
    always @(negedge CLK) begin
        if (bus.mem_wr === 1'b1) begin
            wrAddr.push_back(bus.mem_wadress);
            wrData.push_back(bus.mem_datain);
        end
    end

    // Watchdog so the run ends even if the design locks up.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_mem_wr"}, 64'(bus.mem_wr), 64'd0);
        checkOutput({tag, "_datain"}, 64'(bus.mem_datain), 64'd0);
        checkOutput({tag, "_wadress"}, bus.mem_wadress, BASE);
        checkOutput({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
        checkOutput({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    endtask

    // Pulse start for one cycle with the given length; clears the write log.
    task automatic applyStimulus(input int len);
        @(negedge CLK);
        start     = 1'b1;
        len_words = LW'(len);
        wrAddr.delete();
        wrData.delete();
        @(negedge CLK);
        start     = 1'b0;
    endtask

    // Streams bytes; mode 0 = valid held high, 1 = toggled, 2 = random.
    // byte_ready sampled on the falling edge is what the next rising edge
    // sees, so a transfer is counted exactly when valid and ready meet.
    task automatic sendBytes(input logic [7:0] b[$], input int mode, output bit ok);
        int idx    = 0;
        bit pend   = 1'b0;
        bit tog    = 1'b1;
        int budget = b.size() * 8 + 50;
        bit v;
        ok = 1'b1;
        while (idx < b.size()) begin
            if (budget == 0) begin
                ok = 1'b0;
                break;
            end
            budget--;
            if (pend) idx++;
            pend = 1'b0;
            if (idx < b.size()) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = !tog; end
                    default: v = 1'($urandom_range(0, 1));
                endcase
                bus.byte_in    = b[idx];
                bus.byte_valid = v;
                pend           = v && (bus.byte_ready === 1'b1);
            end else begin
                bus.byte_valid = 1'b0;
            end
            @(negedge CLK);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic waitEnd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || err === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    function automatic logic [7:0] byteSum(input logic [7:0] b[$]);
        int s = 0;
        foreach (b[i]) s += int'(b[i]);
        return 8'(s % 256);
    endfunction

    function automatic logic [31:0] modelWord(input logic [7:0] b[$], input int w);
        return {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
    endfunction

    task automatic compareWrites(input string tag, input logic [7:0] pay[$], input int len);
        int n;
        checkOutput({tag, "_nwrites"}, 64'(wrAddr.size()), 64'(len));
        n = (wrAddr.size() < len) ? wrAddr.size() : len;
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), wrAddr[i], BASE + 64'(4 * i));
            checkOutput($sformatf("%s_data%0d", tag, i), 64'(wrData[i]), 64'(modelWord(pay, i)));
        end
    endtask

    // Full successful load: start, stream, wait, then check image and status.
    task automatic runLoad(input string tag, input int len, input logic [7:0] pay[$], input int mode);
        logic [7:0] stream[$];
        bit ok;
        applyStimulus(len);
        stream = pay;
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(byteSum(pay));
`endif
        sendBytes(stream, mode, ok);
        checkOutput({tag, "_stream_ok"}, 64'(ok), 64'd1);
        waitEnd(ok);
        checkOutput({tag, "_end_ok"}, 64'(ok), 64'd1);
        compareWrites(tag, pay, len);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_err"}, 64'(err), 64'd0);
        checkOutput({tag, "_wadress_after"}, bus.mem_wadress, BASE + 64'(4 * len));
        checkOutput({tag, "_datain_after"}, 64'(bus.mem_datain), 64'(modelWord(pay, len - 1)));
    endtask

    function automatic void randomPayload(input int len, output logic [7:0] q[$]);
        q.delete();
        for (int j = 0; j < 4 * len; j++) q.push_back(8'($urandom_range(0, 255)));
    endfunction

    initial begin
        logic [7:0] pay[$];
        logic [7:0] part[$];
        bit ok;
        int len;

        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;

        repeat (3) @(negedge CLK);
        checkReset("reset");
        RST = 1'b1;
        @(negedge CLK);

        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        runLoad("two_words", 2, pay, 0);

        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        runLoad("toggle", 1, pay, 1);

        // Oversized request: rejected, stream not drained even with valid high.
        bus.byte_valid = 1'b1;
        applyStimulus(MAXW + 1);
        checkOutput("toolong_err", 64'(err), 64'd1);
        checkOutput("toolong_busy", 64'(busy), 64'd0);
        checkOutput("toolong_cpu_hold", 64'(cpu_hold), 64'd1);
        checkOutput("toolong_done", 64'(done), 64'd0);
        repeat (3) @(negedge CLK);
        checkOutput("toolong_byte_ready", 64'(bus.byte_ready), 64'd0);
        checkOutput("toolong_nwrites", 64'(wrAddr.size()), 64'd0);
        bus.byte_valid = 1'b0;

        // Zero-length load finishes immediately and clears the earlier err.
        applyStimulus(0);
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_cpu_hold", 64'(cpu_hold), 64'd0);
        checkOutput("zero_err", 64'(err), 64'd0);
        repeat (2) @(negedge CLK);
        checkOutput("zero_nwrites", 64'(wrAddr.size()), 64'd0);

        // start while busy must be ignored.
        randomPayload(1, pay);
        applyStimulus(1);
        part = '{pay[0], pay[1]};
        sendBytes(part, 0, ok);
        checkOutput("busy_start_stream_ok", 64'(ok), 64'd1);
        start     = 1'b1;
        len_words = '0;
        @(negedge CLK);
        start     = 1'b0;
        checkOutput("busy_start_busy", 64'(busy), 64'd1);
        checkOutput("busy_start_done", 64'(done), 64'd0);
        part = '{pay[2], pay[3]};
`ifdef LOADER_CHECKSUM_EN
        part.push_back(byteSum(pay));
`endif
        sendBytes(part, 2, ok);
        checkOutput("busy_start_stream2_ok", 64'(ok), 64'd1);
        waitEnd(ok);
        checkOutput("busy_start_end_ok", 64'(ok), 64'd1);
        compareWrites("busy_start", pay, 1);
        checkOutput("busy_start_done_end", 64'(done), 64'd1);

        // Reset in the middle of a word: no write, everything back to reset.
        randomPayload(1, pay);
        applyStimulus(1);
        part = '{pay[0], pay[1]};
        sendBytes(part, 0, ok);
        RST = 1'b0;
        @(negedge CLK);
        checkReset("midreset");
        checkOutput("midreset_nwrites", 64'(wrAddr.size()), 64'd0);
        RST = 1'b1;
        @(negedge CLK);
        randomPayload(1, pay);
        runLoad("after_reset", 1, pay, 0);

        // Largest accepted length.
        randomPayload(MAXW, pay);
        runLoad("maxlen", MAXW, pay, 0);

        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(1, 6);
            randomPayload(len, pay);
            runLoad($sformatf("rand%0d", i), len, pay, $urandom_range(0, 2));
        end

`ifdef LOADER_CHECKSUM_EN
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        runLoad("csum_ok", 1, pay, 0);

        applyStimulus(1);
        part = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        sendBytes(part, 0, ok);
        checkOutput("csum_bad_stream_ok", 64'(ok), 64'd1);
        waitEnd(ok);
        checkOutput("csum_bad_end_ok", 64'(ok), 64'd1);
        checkOutput("csum_bad_err", 64'(err), 64'd1);
        checkOutput("csum_bad_cpu_hold", 64'(cpu_hold), 64'd1);
        checkOutput("csum_bad_done", 64'(done), 64'd0);
        checkOutput("csum_bad_nwrites", 64'(wrAddr.size()), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
